quantize_stage: RTL and testbench
=================================

# quantize_stage

Sits directly upstream of the SRAM write-out stage. It drains the skewed systolic-array accumulator outputs for two data sets and turns them into the write-out stage's inputs:

- rounded, saturated `OUTPUT_DATA_WIDTH` lanes
- a `sram_write_enable` strobe
- `data_set` and `matrix_index`

It owns the drain-sequencing FSM. The write-out stage stays purely index-driven.

## Interface

Parameters:
- `ARRAY_SIZE`, 8: systolic array dimension (lanes).
- `ACC_WIDTH`, 32: signed accumulator width per lane.
- `OUTPUT_DATA_WIDTH`, 16: signed quantized width per lane.
- `FILL_LATENCY`, 9: cycles from accepted start to first valid diagonal; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state on the rising edge.
- `srst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to drain one matrix pair.
- `shift`  in  5  right-shift amount, 0..ACC_WIDTH-1; latched on accepted start.
- `ori_data`  in  ARRAY_SIZE*ACC_WIDTH  signed accumulators; lane i at `[i*ACC_WIDTH +: ACC_WIDTH]`.
- `quantized_data`  out  ARRAY_SIZE*OUTPUT_DATA_WIDTH  registered quantized lanes, same lane order.
- `sram_write_enable`  out  1  high on cycles where outputs are valid.
- `data_set`  out  2  0 or 1.
- `matrix_index`  out  6  diagonal index, 0..2*ARRAY_SIZE-2.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse with the final write.

## Operation

FSM states: IDLE → WAIT → DRAIN → IDLE.
- **IDLE**
  - Accepts `start`, latches `shift`, clears the wait counter, goes to WAIT.
  - `start` is ignored in WAIT and DRAIN.
- **WAIT**
  - Counts `FILL_LATENCY` cycles, then goes to DRAIN with set=0, idx=0.
- **DRAIN**
  - Samples `ori_data` every cycle.
  - idx increments 0..DIAG-1, where DIAG = 2*ARRAY_SIZE-1 (15 for the default).
  - At idx=DIAG-1 with set=0: set→1, idx→0, no gap cycle.
  - At idx=DIAG-1 with set=1: go to IDLE.
  - Total of 2*DIAG samples.

Per-lane arithmetic, identical for every lane:
- Extend the accumulator to ACC_WIDTH+1 bits.
- Add the rounding constant `1<<(shift-1)` if shift>0, else add 0 (round half up).
- Arithmetic right shift by `shift`.
- Saturate to [−2^(OUTPUT_DATA_WIDTH−1), 2^(OUTPUT_DATA_WIDTH−1)−1].
- All lanes are passed through. Masking lanes that are invalid for a diagonal is the downstream stage's job.

Register contents:
- The output register loads quantized lanes, `data_set`, `matrix_index` and `sram_write_enable`=1 when the sample cycle is in DRAIN.
- Otherwise it loads `sram_write_enable`=0, `quantized_data`=0, `data_set`=0, `matrix_index`=0.
- `done`=1 in the same registered cycle as the output for (set 1, idx DIAG-1).

## Timing

- `start` sampled at edge E0.
- Sample k (k = 0..2*DIAG-1) is taken at edge E0+FILL_LATENCY+1+k.
- Each sample's output is visible immediately after that same edge (latency 1 register).
- `busy` rises after E0 and falls after the final-sample edge; it is a registered state decode.
- A `start` on the cycle `busy` falls (IDLE again) is accepted: back-to-back runs are legal.
- `srst` at any edge:
  - state→IDLE; all outputs 0 after that edge; counters cleared.
  - Any partial run is abandoned with no `done`.
  - `srst` dominates a simultaneous `start`.
- The latched `shift` is used for the whole run. Changes on the `shift` port mid-run have no effect.

## Structure

- Shared package holds:
  - the FSM state enum (IDLE, WAIT, DRAIN);
  - `DIAG_COUNT` = 2*ARRAY_SIZE−1;
  - the `sat_round` width helper constants.
- One sub-module, `quant_lane`: combinational round/shift/saturate for one lane, generated ARRAY_SIZE times.
- The FSM, counters and output register live in the top module.

## Test plan

All scenarios use default parameters unless stated.

- **Rounding**
  - Stimulus: shift=4; lane0 = 24, lane1 = −24, lane2 = 7, lane3 = 8.
  - Required: outputs 2, −1, 0, 1 respectively.
- **Saturation**
  - Stimulus: shift=4; lane0 = 0x00200000, lane1 = −0x00200000.
  - Required: 0x7FFF and 0x8000.
- **Zero shift**
  - Stimulus: shift=0; lane = 5 and lane = −40000.
  - Required: 5 and 0x8000.
- **Full sequence**
  - Stimulus: start at E0, FILL_LATENCY=9.
  - Required:
    - `sram_write_enable` high for exactly 30 consecutive cycles, starting after edge E0+10.
    - Indices 0..14 with set 0, then 0..14 with set 1.
    - `done` on the last of those cycles only.
    - A `start` during the run is ignored.
- **Reset mid-run**
  - Stimulus: assert `srst` during set 0, idx 6.
  - Required:
    - All outputs 0 and `busy` low after the edge; no `done`.
    - A new `start` afterwards produces the full 30-write sequence from idx 0.
- **Back-to-back runs**
  - Stimulus: `start` on the cycle after `done`.
  - Required: the second run's first write arrives FILL_LATENCY+1 edges later, with set 0, idx 0.

Source files
------------

// File: rtl/quantize_stage_pkg.sv
// rtl/quantize_stage_pkg.sv - shared FSM type, widths and diagonal helpers for quantize_stage
package quantize_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int DEFAULT_ARRAY_SIZE = 8;
   localparam int DIAG_COUNT         = 2 * DEFAULT_ARRAY_SIZE - 1;

   localparam int SHIFT_W = 5;
   localparam int SET_W   = 2;
   localparam int IDX_W   = 6;

   // One extra headroom bit so the rounding add on a full-scale accumulator cannot wrap
   localparam int SAT_GUARD_BITS = 1;

   function automatic int diag_count(input int array_size);
      return 2 * array_size - 1;
   endfunction

endpackage

// File: rtl/quantize_stage_lane.sv
// rtl/quantize_stage_lane.sv - combinational round-half-up, arithmetic shift and saturate for one lane
module quant_lane
   import quantize_stage_pkg::*;
#(
   parameter int ACC_WIDTH         = 32,
   parameter int OUTPUT_DATA_WIDTH = 16
) (
   input  logic [ACC_WIDTH-1:0]         acc_in,
   input  logic [SHIFT_W-1:0]           shift,
   output logic [OUTPUT_DATA_WIDTH-1:0] q_out
);

   localparam int EXT_W = ACC_WIDTH + SAT_GUARD_BITS;

   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W - OUTPUT_DATA_WIDTH + 1){1'b0}}, {(OUTPUT_DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W - OUTPUT_DATA_WIDTH + 1){1'b1}}, {(OUTPUT_DATA_WIDTH - 1){1'b0}}};

   logic signed [EXT_W-1:0] ext;
   logic signed [EXT_W-1:0] round_c;
   logic signed [EXT_W-1:0] sum;
   logic signed [EXT_W-1:0] shifted;

   // Widen, add half an output LSB, shift down, then clamp into the output range
   always_comb begin
      ext     = EXT_W'($signed(acc_in));
      round_c = '0;
      if (shift != '0) begin
         round_c = EXT_W'(1) << (shift - SHIFT_W'(1));
      end
      sum     = ext + round_c;
      shifted = sum >>> shift;
      if (shifted > SAT_MAX) begin
         q_out = SAT_MAX[OUTPUT_DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         q_out = SAT_MIN[OUTPUT_DATA_WIDTH-1:0];
      end else begin
         q_out = shifted[OUTPUT_DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/quantize_stage.sv
// rtl/quantize_stage.sv - drain sequencer and quantizing output register ahead of SRAM write-out
module quantize_stage
   import quantize_stage_pkg::*;
#(
   parameter int ARRAY_SIZE        = 8,
   parameter int ACC_WIDTH         = 32,
   parameter int OUTPUT_DATA_WIDTH = 16,
   parameter int FILL_LATENCY      = 9
) (
   input  logic                                    clk,
   input  logic                                    srst,
   input  logic                                    start,
   input  logic [SHIFT_W-1:0]                      shift,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]         ori_data,
   output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
   output logic                                    sram_write_enable,
   output logic [SET_W-1:0]                        data_set,
   output logic [IDX_W-1:0]                        matrix_index,
   output logic                                    busy,
   output logic                                    done
);

   localparam int DIAG   = diag_count(ARRAY_SIZE);
   localparam int WCNT_W = (FILL_LATENCY > 1) ? $clog2(FILL_LATENCY) : 1;
   localparam int QW     = ARRAY_SIZE * OUTPUT_DATA_WIDTH;

   localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(FILL_LATENCY - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIAG - 1);

   state_t             state_q, state_d;
   logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               set_q, set_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [QW-1:0]      qdata_q, qdata_d;
   logic               wen_q, wen_d;
   logic [SET_W-1:0]   dset_q, dset_d;
   logic [IDX_W-1:0]   midx_q, midx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [QW-1:0]      lanes;

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      quant_lane #(
         .ACC_WIDTH         (ACC_WIDTH),
         .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH)
      ) u_lane (
         .acc_in (ori_data[i*ACC_WIDTH +: ACC_WIDTH]),
         .shift  (shift_q),
         .q_out  (lanes[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH])
      );
   end

   // Next-state, counters and next output-register contents
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      idx_d      = idx_q;
      set_d      = set_q;
      shift_d    = shift_q;
      wen_d      = 1'b0;
      qdata_d    = '0;
      dset_d     = '0;
      midx_d     = '0;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_WAIT;
               shift_d    = shift;
               wait_cnt_d = '0;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == LAST_WAIT) begin
               state_d = ST_DRAIN;
               set_d   = 1'b0;
               idx_d   = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
         end
         ST_DRAIN: begin
            wen_d   = 1'b1;
            qdata_d = lanes;
            dset_d  = {{(SET_W-1){1'b0}}, set_q};
            midx_d  = idx_q;
            if (idx_q == LAST_IDX) begin
               idx_d = '0;
               if (set_q) begin
                  state_d = ST_IDLE;
                  set_d   = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  set_d = 1'b1;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, counters and output register; reset abandons any run without done
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         idx_q      <= '0;
         set_q      <= 1'b0;
         shift_q    <= '0;
         qdata_q    <= '0;
         wen_q      <= 1'b0;
         dset_q     <= '0;
         midx_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         idx_q      <= idx_d;
         set_q      <= set_d;
         shift_q    <= shift_d;
         qdata_q    <= qdata_d;
         wen_q      <= wen_d;
         dset_q     <= dset_d;
         midx_q     <= midx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign quantized_data    = qdata_q;
   assign sram_write_enable = wen_q;
   assign data_set          = dset_q;
   assign matrix_index      = midx_q;
   assign busy              = busy_q;
   assign done              = done_q;

endmodule

// File: tb/tb_quantize_stage.sv
// tb/tb_quantize_stage.sv - self-checking bench for quantize_stage with timeline model
module tb_quantize_stage;

   localparam int FL = 9;
   localparam int D  = 15;

   logic         clk;
   logic         srst;
   logic         start;
   logic [4:0]   shift;
   logic [255:0] ori_data;
   logic [127:0] quantized_data;
   logic         sram_write_enable;
   logic [1:0]   data_set;
   logic [5:0]   matrix_index;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   quantize_stage #(
      .ARRAY_SIZE        (8),
      .ACC_WIDTH         (32),
      .OUTPUT_DATA_WIDTH (16),
      .FILL_LATENCY      (FL)
   ) dut (
      .clk               (clk),
      .srst              (srst),
      .start             (start),
      .shift             (shift),
      .ori_data          (ori_data),
      .quantized_data    (quantized_data),
      .sram_write_enable (sram_write_enable),
      .data_set          (data_set),
      .matrix_index      (matrix_index),
      .busy              (busy),
      .done              (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic: floor((x + half) / 2^s), clamped to int16
   function automatic logic [127:0] model_lanes(input logic [255:0] d, input int s);
      logic [127:0] r;
      longint       v;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         v = longint'($signed(d[i*32 +: 32]));
         if (s > 0) v = v + (longint'(1) <<< (s - 1));
         v = v >>> s;
         if (v > 32767) v = 32767;
         else if (v < -32768) v = -32768;
         r[i*16 +: 16] = v[15:0];
      end
      return r;
   endfunction

   // Timeline model: edges since accepted start decide what each output register holds
   logic         m_active = 1'b0;
   int           m_t      = 0;
   int           mk;
   int           m_shift  = 0;
   logic         e_wen    = 1'b0;
   logic [127:0] e_q      = '0;
   logic [1:0]   e_set    = '0;
   logic [5:0]   e_idx    = '0;
   logic         e_done   = 1'b0;
   logic         e_busy   = 1'b0;

   always @(posedge clk) begin
      if (srst) begin
         m_active <= 1'b0;
         e_wen    <= 1'b0;
         e_q      <= '0;
         e_set    <= '0;
         e_idx    <= '0;
         e_done   <= 1'b0;
         e_busy   <= 1'b0;
      end else begin
         e_wen  <= 1'b0;
         e_q    <= '0;
         e_set  <= '0;
         e_idx  <= '0;
         e_done <= 1'b0;
         if (!m_active) begin
            if (start) begin
               m_active <= 1'b1;
               m_t      <= 0;
               m_shift  <= int'(shift);
               e_busy   <= 1'b1;
            end
         end else begin
            mk = m_t + 1 - (FL + 1);
            m_t <= m_t + 1;
            if (mk >= 0) begin
               e_wen <= 1'b1;
               e_set <= 2'(mk / D);
               e_idx <= 6'(mk % D);
               e_q   <= model_lanes(ori_data, m_shift);
               if (mk == 2 * D - 1) begin
                  e_done   <= 1'b1;
                  m_active <= 1'b0;
                  e_busy   <= 1'b0;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      check("wen",  {127'd0, sram_write_enable}, {127'd0, e_wen});
      check("set",  {126'd0, data_set},          {126'd0, e_set});
      check("idx",  {122'd0, matrix_index},      {122'd0, e_idx});
      check("done", {127'd0, done},              {127'd0, e_done});
      check("busy", {127'd0, busy},              {127'd0, e_busy});
      check("qdata", quantized_data, e_q);
   end

   // Starts a run at the current negedge and watches it; optionally resets just before idx rst_idx of set 0
   task automatic do_run(input logic [4:0] sh, input bit poke, input int rst_idx,
                         output int lat, output int writes, output int dones,
                         output bit seq_ok, output logic [127:0] first_q);
      int e;
      bit fin;
      lat = -1; writes = 0; dones = 0; seq_ok = 1'b1; first_q = '0; fin = 1'b0;
      start = 1'b1;
      shift = sh;
      @(negedge clk);
      start = 1'b0;
      e = 0;
      while (!fin && e < 80) begin
         @(negedge clk);
         e++;
         shift = 5'($urandom_range(0, 31));
         ori_data[255:128] = {$urandom, $urandom, $urandom, $urandom};
         start = poke && (e == 20);
         if (sram_write_enable) begin
            if (writes == 0) begin
               lat     = e;
               first_q = quantized_data;
            end
            if (data_set != 2'(writes / D) || matrix_index != 6'(writes % D)) seq_ok = 1'b0;
            if (e != lat + writes) seq_ok = 1'b0;
            writes++;
            if (done) begin
               dones++;
               fin = 1'b1;
            end
            if (rst_idx >= 0 && data_set == 2'd0 && int'(matrix_index) == rst_idx - 1) begin
               srst  = 1'b1;
               start = 1'b1;
               @(negedge clk);
               check("rst_wen",  {127'd0, sram_write_enable}, 128'd0);
               check("rst_busy", {127'd0, busy}, 128'd0);
               check("rst_done", {127'd0, done}, 128'd0);
               check("rst_q",    quantized_data, 128'd0);
               check("rst_idx",  {122'd0, matrix_index}, 128'd0);
               srst  = 1'b0;
               start = 1'b0;
               fin   = 1'b1;
            end
         end
      end
      start = 1'b0;
      check("run_finished", {127'd0, fin}, 128'd1);
   endtask

   int           lat, writes, dones;
   bit           seq_ok;
   logic [127:0] fq;

   initial begin
      srst = 1'b1; start = 1'b0; shift = '0; ori_data = '0;
      repeat (3) @(negedge clk);
      check("reset_wen",  {127'd0, sram_write_enable}, 128'd0);
      check("reset_busy", {127'd0, busy}, 128'd0);
      check("reset_q",    quantized_data, 128'd0);
      srst = 1'b0;
      @(negedge clk);

      // Rounding plus full sequence, with an ignored start mid-run
      ori_data[0 +: 32]  = 32'sd24;
      ori_data[32 +: 32] = -32'sd24;
      ori_data[64 +: 32] = 32'sd7;
      ori_data[96 +: 32] = 32'sd8;
      do_run(5'd4, 1'b1, -1, lat, writes, dones, seq_ok, fq);
      check("r1_lat",    128'(lat), 128'd10);
      check("r1_writes", 128'(writes), 128'd30);
      check("r1_dones",  128'(dones), 128'd1);
      check("r1_seq",    {127'd0, seq_ok}, 128'd1);
      check("round_24",  {112'd0, fq[15:0]},  128'h0002);
      check("round_m24", {112'd0, fq[31:16]}, 128'hFFFF);
      check("round_7",   {112'd0, fq[47:32]}, 128'h0000);
      check("round_8",   {112'd0, fq[63:48]}, 128'h0001);

      // Back-to-back: start on the cycle after done; saturation vectors
      ori_data[0 +: 32]  = 32'sh0020_0000;
      ori_data[32 +: 32] = -32'sh0020_0000;
      do_run(5'd4, 1'b0, -1, lat, writes, dones, seq_ok, fq);
      check("b2b_lat",    128'(lat), 128'd10);
      check("b2b_writes", 128'(writes), 128'd30);
      check("b2b_seq",    {127'd0, seq_ok}, 128'd1);
      check("sat_pos",    {112'd0, fq[15:0]},  128'h7FFF);
      check("sat_neg",    {112'd0, fq[31:16]}, 128'h8000);

      // Zero shift
      repeat (3) @(negedge clk);
      ori_data[0 +: 32]  = 32'sd5;
      ori_data[32 +: 32] = -32'sd40000;
      do_run(5'd0, 1'b0, -1, lat, writes, dones, seq_ok, fq);
      check("zs_writes", 128'(writes), 128'd30);
      check("zs_5",      {112'd0, fq[15:0]},  128'h0005);
      check("zs_m40000", {112'd0, fq[31:16]}, 128'h8000);

      // Reset during set 0 idx 6 (with a simultaneous start), then a clean full run
      repeat (2) @(negedge clk);
      do_run(5'd4, 1'b0, 6, lat, writes, dones, seq_ok, fq);
      check("rst_writes", 128'(writes), 128'd6);
      check("rst_dones",  128'(dones), 128'd0);
      repeat (2) @(negedge clk);
      do_run(5'd3, 1'b0, -1, lat, writes, dones, seq_ok, fq);
      check("post_lat",    128'(lat), 128'd10);
      check("post_writes", 128'(writes), 128'd30);
      check("post_dones",  128'(dones), 128'd1);
      check("post_seq",    {127'd0, seq_ok}, 128'd1);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
